// File: rtl/pipelined_wallace_multiplier_if.sv
// Operand/result bundle for pipelined_wallace_multiplier.
// Defining SIGNED_MODE_EN adds the per-transaction in_signed flag.
interface pipelined_wallace_multiplier_if #(
    parameter int WIDTH = 8,
    parameter int TAG_W = 4
);
    // Both sides are valid/ready: a beat transfers on the rising edge where valid && ready are
    // both high; a producer keeps valid and payload steady until that edge, and ready may
    // depend combinationally on the far side (in_ready follows out_ready in the same cycle).
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_a;
    logic [WIDTH-1:0]     in_b;
    logic [TAG_W-1:0]     in_tag;
`ifdef SIGNED_MODE_EN
    logic                 in_signed;
`endif
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   out_product;
    logic [TAG_W-1:0]     out_tag;

`ifdef SIGNED_MODE_EN
    modport master (
        output in_valid, in_a, in_b, in_tag, in_signed, out_ready,
        input  in_ready, out_valid, out_product, out_tag
    );
    modport slave (
        input  in_valid, in_a, in_b, in_tag, in_signed, out_ready,
        output in_ready, out_valid, out_product, out_tag
    );
`else
    modport master (
        output in_valid, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_product, out_tag
    );
    modport slave (
        input  in_valid, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_product, out_tag
    );
`endif
endinterface

// File: rtl/pipelined_wallace_multiplier.sv
// Three-stage WIDTH x WIDTH Wallace-tree multiplier with tag and valid/ready flow control.
// SIGNED_MODE_EN enables per-transaction two's-complement (Baugh-Wooley) products.
module pipelined_wallace_multiplier #(
    parameter int WIDTH = 8,
    parameter int TAG_W = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    pipelined_wallace_multiplier_if.slave bus
);
    localparam int PW     = 2 * WIDTH;
    localparam int MAXH   = 3 * ((WIDTH + 6) / 3);
    localparam int HW     = $clog2(MAXH);
    localparam int LAYERS = 10;

    logic             advance;
    logic             s1_valid;
    logic             s2_valid;
    logic             out_valid_q;
    logic [WIDTH-1:0] pp_d  [WIDTH];
    logic [WIDTH-1:0] s1_pp [WIDTH];
    logic [TAG_W-1:0] s1_tag;
    logic [TAG_W-1:0] s2_tag;
    logic [TAG_W-1:0] out_tag_q;
    logic [PW-1:0]    sum_d;
    logic [PW-1:0]    carry_d;
    logic [PW-1:0]    s2_sum;
    logic [PW-1:0]    s2_carry;
    logic [PW-1:0]    out_product_q;
`ifdef SIGNED_MODE_EN
    logic             s1_signed;
`endif

    // Whole pipeline moves as one; a stalled output register freezes every stage behind it.
    assign advance          = !out_valid_q || bus.out_ready;
    assign bus.in_ready     = advance;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_product  = out_product_q;
    assign bus.out_tag      = out_tag_q;

    // S1 input: row i holds a & b[i], implicitly weighted by 2^i.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            pp_d[i] = bus.in_a & {WIDTH{bus.in_b[i]}};
        end
`ifdef SIGNED_MODE_EN
        // Baugh-Wooley: terms pairing exactly one sign bit with a non-sign bit are inverted.
        if (bus.in_signed) begin
            for (int i = 0; i < WIDTH; i++) begin
                for (int j = 0; j < WIDTH; j++) begin
                    if ((i == WIDTH - 1) != (j == WIDTH - 1)) begin
                        pp_d[i][j] = ~pp_d[i][j];
                    end
                end
            end
        end
`endif
    end

    // S2 input: greedy per-column 3:2 / 2:2 reduction until every column holds at most two bits.
    // Column PW is a sink for carries beyond the product width and is never read.
    always_comb begin : wallace_tree
        logic [MAXH-1:0] m    [PW+1];
        logic [MAXH-1:0] nm   [PW+1];
        int              cnt  [PW+1];
        int              ncnt [PW+1];
        logic            busy;
        logic            x;
        logic            y;
        logic            z;

        busy = 1'b0;
        x    = 1'b0;
        y    = 1'b0;
        z    = 1'b0;
        for (int c = 0; c <= PW; c++) begin
            m[c]    = '0;
            nm[c]   = '0;
            cnt[c]  = 0;
            ncnt[c] = 0;
        end

        for (int i = 0; i < WIDTH; i++) begin
            for (int j = 0; j < WIDTH; j++) begin
                m[i + j][HW'(cnt[i + j])] = s1_pp[i][j];
                cnt[i + j] = cnt[i + j] + 1;
            end
        end
`ifdef SIGNED_MODE_EN
        m[WIDTH][HW'(cnt[WIDTH])] = s1_signed;
        cnt[WIDTH] = cnt[WIDTH] + 1;
        m[PW-1][HW'(cnt[PW-1])] = s1_signed;
        cnt[PW-1] = cnt[PW-1] + 1;
`endif

        for (int l = 0; l < LAYERS; l++) begin
            busy = 1'b0;
            for (int c = 0; c < PW; c++) begin
                busy = busy | (cnt[c] > 2);
            end
            if (busy) begin
                for (int c = 0; c <= PW; c++) begin
                    nm[c]   = '0;
                    ncnt[c] = 0;
                end
                for (int c = 0; c < PW; c++) begin
                    for (int g = 0; g < MAXH; g += 3) begin
                        if (g + 2 < cnt[c]) begin
                            x = m[c][g];
                            y = m[c][g+1];
                            z = m[c][g+2];
                            nm[c][HW'(ncnt[c])] = x ^ y ^ z;
                            ncnt[c] = ncnt[c] + 1;
                            nm[c+1][HW'(ncnt[c+1])] = (x & y) | (x & z) | (y & z);
                            ncnt[c+1] = ncnt[c+1] + 1;
                        end else if (g + 1 < cnt[c]) begin
                            x = m[c][g];
                            y = m[c][g+1];
                            nm[c][HW'(ncnt[c])] = x ^ y;
                            ncnt[c] = ncnt[c] + 1;
                            nm[c+1][HW'(ncnt[c+1])] = x & y;
                            ncnt[c+1] = ncnt[c+1] + 1;
                        end else if (g < cnt[c]) begin
                            nm[c][HW'(ncnt[c])] = m[c][g];
                            ncnt[c] = ncnt[c] + 1;
                        end
                    end
                end
                for (int c = 0; c <= PW; c++) begin
                    m[c]   = nm[c];
                    cnt[c] = ncnt[c];
                end
            end
        end

        for (int c = 0; c < PW; c++) begin
            sum_d[c]   = m[c][0];
            carry_d[c] = m[c][1];
        end
    end

    // Valid bits and the visible output registers are the only reset state.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid      <= 1'b0;
            s2_valid      <= 1'b0;
            out_valid_q   <= 1'b0;
            out_product_q <= '0;
            out_tag_q     <= '0;
        end else if (advance) begin
            s1_valid    <= bus.in_valid;
            s2_valid    <= s1_valid;
            out_valid_q <= s2_valid;
            if (s2_valid) begin
                out_product_q <= s2_sum + s2_carry;
                out_tag_q     <= s2_tag;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (advance) begin
            s1_pp    <= pp_d;
            s1_tag   <= bus.in_tag;
            s2_sum   <= sum_d;
            s2_carry <= carry_d;
            s2_tag   <= s1_tag;
        end
    end

`ifdef SIGNED_MODE_EN
    always_ff @(posedge clk) begin
        if (advance) begin
            s1_signed <= bus.in_signed;
        end
    end
`endif

endmodule

// File: doc/pipelined_wallace_multiplier.md
# pipelined_wallace_multiplier

Parametrised, three-stage pipelined unsigned (optionally signed) Wallace-tree multiplier with valid/ready handshakes on both sides. It generalises the team's fixed 4x4 combinational Wallace multiplier to WIDTH x WIDTH operands. It sustains one product per clock and carries a user tag alongside each operand pair. It sits between an operand producer and a result consumer in the datapath and tolerates back-pressure.

## Interface
- WIDTH, default 8: operand width in bits. Legal range 2..16; product is 2*WIDTH bits.
- TAG_W, default 4: width of the opaque tag carried with each transaction. Legal range 1..16.
- clk  input  1  rising-edge clock, single clock domain.
- rst  input  1  reset: synchronous, active-high.
- in_valid  input  1  operand pair and tag are valid.
- in_ready  output  1  block accepts a transaction this cycle.
- in_a  input  WIDTH  multiplicand.
- in_b  input  WIDTH  multiplier.
- in_tag  input  TAG_W  user tag, returned unchanged with the product.
- in_signed  input  1  two's-complement mode for this transaction. Present only with SIGNED_MODE_EN.
- out_valid  output  1  out_product and out_tag are valid.
- out_ready  input  1  consumer accepts the result this cycle.
- out_product  output  2*WIDTH  in_a * in_b.
- out_tag  output  TAG_W  tag of this result.

## Operation
- A transaction is accepted on a rising edge where in_valid && in_ready are both high.
- A result is consumed on a rising edge where out_valid && out_ready are both high.
- Pipeline stages:
  - S1 registers the WIDTH partial-product rows (a AND b[i] shifted by i), the tag, and a valid bit.
  - S2 reduces the rows with a Wallace tree of full/half adders (3:2 and 2:2 counters, applied greedily per weight column) to two 2*WIDTH-bit rows, registered with tag and valid.
  - S3 adds the two rows with a 2*WIDTH-bit carry-propagate adder into the output register.
- Global advance = !out_valid || out_ready. When advance is low, all stages (data, tag, valid) hold.
- in_ready = advance. It is a combinational path from out_ready; there is no skid buffer.
- Bubbles (stages with valid=0) advance like data. They are not collapsed.
- Results are in-order. Every accepted transaction yields exactly one result; there is no drop and no duplication.
- Arithmetic, unsigned: out_product = in_a * in_b, exact in 2*WIDTH bits, no overflow possible.
- Data and tag in a stage whose valid bit is 0 are don't-care internally. out_product and out_tag hold their last value while out_valid is 0.

## Timing
- Latency 3: a pair accepted at the end of cycle c appears with out_valid=1 in cycle c+3, provided advance stays high.
- Throughput: one transaction per cycle while out_ready stays high.
- Each cycle with advance=0 adds one cycle of latency to every in-flight transaction.
- While out_valid=1 and out_ready=0, out_product and out_tag are stable and in_ready=0.
- Reset, synchronous, in the cycle rst is sampled high:
  - All stage valid bits clear, so out_valid=0.
  - out_product=0 and out_tag=0.
  - in_ready=1 on the cycle after reset, since out_valid=0.
  - Any in-flight transactions are discarded without a result.
  - A transaction presented during the reset cycle is not accepted.
- Acceptance and consumption in the same cycle are legal and keep the pipeline full.

## Configuration
- Macro: SIGNED_MODE_EN.
- Defined:
  - The in_signed port exists and travels with its transaction through S1..S3.
  - When in_signed=1, operands are two's complement and partial products use the Baugh-Wooley form: the sign-row/column terms are inverted and correction constants are added at weights WIDTH and 2*WIDTH-1.
  - out_product is then the signed product, exact in 2*WIDTH bits.
  - When in_signed=0, behaviour is identical to the unsigned build.
- Undefined: no in_signed port, unsigned only, and no correction logic is synthesised.

## Test plan
- Reset, then idle: rst high for 2 cycles -> out_valid=0, out_product=0, out_tag=0, and in_ready=1 on the first cycle after reset.
- Single transaction, WIDTH=8: a=255, b=255, tag=5 -> out_product=65025 (0xFE01) with out_tag=5 exactly 3 cycles after acceptance. At WIDTH=4, a=15, b=15 -> 225.
- Streaming: 20 back-to-back random pairs with out_ready=1 -> 20 correct in-order results on consecutive cycles, first result at acceptance+3.
- Back-pressure: pipeline full, out_ready=0 for 4 cycles -> in_ready=0, and out_product and out_tag frozen. After out_ready returns to 1, the remaining results drain in order with none lost or duplicated.
- Reset mid-flight: 3 transactions in flight, rst pulsed for 1 cycle -> no results emerge. A subsequent a=9, b=5 yields 45 at acceptance+3.
- SIGNED_MODE_EN build, WIDTH=8:
  - in_signed=1, a=-128, b=-128 -> 16384.
  - in_signed=1, a=-1, b=1 -> 0xFFFF.
  - in_signed=0, a=0xFF, b=0x01 -> 0x00FF.
